// File: rtl/cl_frame_capture_if.sv
// rtl/cl_frame_capture_if.sv - packer-side bus of the CameraLink frame gate
// Purpose: carries the qualified pixel stream and frame markers to the DMA packer.
// Signals:
//   data_out   48-bit pixel beat, upper half zero in 24-bit mode
//   data_vld   beat strobe, high exactly on captured beats
//   data_sel   1 = 48-bit beats, latched at arm
//   data_end   level, frame finished; held until the next frame_rst or abort
//   frame_rst  1-cycle pulse at the start of a captured frame
interface cl_frame_capture_if;
  logic [47:0] data_out;
  logic        data_vld;
  logic        data_sel;
  logic        data_end;
  logic        frame_rst;

  modport master (output data_out, data_vld, data_sel, data_end, frame_rst);
  modport slave  (input  data_out, data_vld, data_sel, data_end, frame_rst);
endinterface

// File: rtl/cl_frame_capture.sv
// rtl/cl_frame_capture.sv - CameraLink frame gate feeding the DMA packer
// Purpose: qualifies pixels with FVAL/LVAL/DVAL and captures one whole frame per arm.
// Ports:
//   sys_clk, reset        clock, async active-high reset
//   cl_fval/lval/dval     CameraLink qualifiers (already in sys_clk domain)
//   cl_data[47:0]         pixel data, [23:0] used in 24-bit mode
//   mode_48               beat width select, sampled on arm
//   arm, abort            1-cycle control pulses
//   max_lines, max_beats  per-frame line limit / per-line beat limit, 0 = unlimited
//   pk                    packer bus (data_out, data_vld, data_sel, data_end, frame_rst)
//   busy, frame_done      status; frame_done pulses on entry to DONE
//   line_cnt              lines captured in the last/current frame
//   err_long_line         sticky: beats dropped by max_beats
//   err_overrun           sticky: FVAL still high when max_lines was reached
module cl_frame_capture #(
  parameter int LINE_W = 16,
  parameter int PIX_W  = 16
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  cl_fval,
  input  logic                  cl_lval,
  input  logic                  cl_dval,
  input  logic [47:0]           cl_data,
  input  logic                  mode_48,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [LINE_W-1:0]     max_lines,
  input  logic [PIX_W-1:0]      max_beats,
  cl_frame_capture_if.master    pk,
  output logic                  busy,
  output logic                  frame_done,
  output logic [LINE_W-1:0]     line_cnt,
  output logic                  err_long_line,
  output logic                  err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_FV,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Input stage plus one-cycle-older copies for edge detection.
  logic        fval_q, lval_q, dval_q;
  logic        fval_p_q, lval_p_q;
  logic [47:0] data_q;

  logic [47:0]       data_out_q, data_out_d;
  logic              data_vld_q, data_vld_d;
  logic              data_sel_q, data_sel_d;
  logic              data_end_q, data_end_d;
  logic              frame_rst_q, frame_rst_d;
  logic              frame_done_q, frame_done_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [PIX_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              err_ll_q, err_ll_d;
  logic              err_ov_q, err_ov_d;

  logic fval_rise, fval_fall, lval_fall;
  logic raw_beat, beat_ok, beat, lines_hit;

  assign fval_rise = fval_q & ~fval_p_q;
  assign fval_fall = ~fval_q & fval_p_q;
  assign lval_fall = ~lval_q & lval_p_q;
  assign raw_beat  = fval_q & lval_q & dval_q;
  assign beat_ok   = (max_beats == '0) || (beat_cnt_q < max_beats);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      fval_q   <= 1'b0;
      lval_q   <= 1'b0;
      dval_q   <= 1'b0;
      fval_p_q <= 1'b0;
      lval_p_q <= 1'b0;
      data_q   <= '0;
    end else begin
      fval_q   <= cl_fval;
      lval_q   <= cl_lval;
      dval_q   <= cl_dval;
      fval_p_q <= fval_q;
      lval_p_q <= lval_q;
      data_q   <= cl_data;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      data_out_q   <= '0;
      data_vld_q   <= 1'b0;
      data_sel_q   <= 1'b0;
      data_end_q   <= 1'b0;
      frame_rst_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      err_ll_q     <= 1'b0;
      err_ov_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      data_vld_q   <= data_vld_d;
      data_sel_q   <= data_sel_d;
      data_end_q   <= data_end_d;
      frame_rst_q  <= frame_rst_d;
      frame_done_q <= frame_done_d;
      line_cnt_q   <= line_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      err_ll_q     <= err_ll_d;
      err_ov_q     <= err_ov_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    data_vld_d   = 1'b0;
    data_sel_d   = data_sel_q;
    data_end_d   = data_end_q;
    frame_rst_d  = 1'b0;
    frame_done_d = 1'b0;
    line_cnt_d   = line_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    err_ll_d     = err_ll_q;
    err_ov_d     = err_ov_q;
    lines_hit    = 1'b0;
    beat         = 1'b0;

    case (state_q)
      // DONE accepts a re-arm like IDLE; data_end keeps holding until frame_rst.
      S_IDLE, S_DONE: begin
        if (arm) begin
          data_sel_d = mode_48;
          err_ll_d   = 1'b0;
          err_ov_d   = 1'b0;
          state_d    = fval_q ? S_WAIT_IDLE : S_WAIT_FV;
        end
      end

      // Let a frame already in flight pass so only whole frames are captured.
      S_WAIT_IDLE: begin
        if (!fval_q) state_d = S_WAIT_FV;
      end

      S_WAIT_FV: begin
        if (fval_rise) begin
          frame_rst_d = 1'b1;
          data_end_d  = 1'b0;
          line_cnt_d  = '0;
          beat_cnt_d  = '0;
          state_d     = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (lval_fall) begin
          if (line_cnt_q != '1) line_cnt_d = line_cnt_q + LINE_W'(1);
          beat_cnt_d = '0;
        end
        // Uses the updated count so the frame closes on the very line that reaches
        // the limit, before any beat of the following line can slip through.
        lines_hit = (max_lines != '0) && (line_cnt_d >= max_lines);
        beat      = raw_beat & beat_ok & ~lines_hit;

        if (raw_beat && !beat_ok && !lines_hit) err_ll_d = 1'b1;

        if (beat) begin
          data_vld_d = 1'b1;
          data_out_d = data_sel_q ? data_q : {24'h0, data_q[23:0]};
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + PIX_W'(1);
        end

        if (lines_hit || fval_fall) begin
          if (lines_hit && fval_q) err_ov_d = 1'b1;
          data_end_d   = 1'b1;
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      data_vld_d   = 1'b0;
      data_end_d   = 1'b0;
      frame_rst_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  assign pk.data_out  = data_out_q;
  assign pk.data_vld  = data_vld_q;
  assign pk.data_sel  = data_sel_q;
  assign pk.data_end  = data_end_q;
  assign pk.frame_rst = frame_rst_q;

  assign busy          = (state_q == S_WAIT_IDLE) || (state_q == S_WAIT_FV) ||
                         (state_q == S_ACTIVE);
  assign frame_done    = frame_done_q;
  assign line_cnt      = line_cnt_q;
  assign err_long_line = err_ll_q;
  assign err_overrun   = err_ov_q;

endmodule

// File: tb/tb_cl_frame_capture.sv
// tb/tb_cl_frame_capture.sv - self-checking bench for cl_frame_capture
module tb_cl_frame_capture;

  logic        sys_clk;
  logic        reset;
  logic        cl_fval, cl_lval, cl_dval;
  logic [47:0] cl_data;
  logic        mode_48, arm, abort;
  logic [15:0] max_lines, max_beats;
  logic        busy, frame_done, err_long_line, err_overrun;
  logic [15:0] line_cnt;

  cl_frame_capture_if pk();

  cl_frame_capture dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .cl_fval      (cl_fval),
    .cl_lval      (cl_lval),
    .cl_dval      (cl_dval),
    .cl_data      (cl_data),
    .mode_48      (mode_48),
    .arm          (arm),
    .abort        (abort),
    .max_lines    (max_lines),
    .max_beats    (max_beats),
    .pk           (pk),
    .busy         (busy),
    .frame_done   (frame_done),
    .line_cnt     (line_cnt),
    .err_long_line(err_long_line),
    .err_overrun  (err_overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int mode;
    int nl;
    int nb;
    int ml;
    int mb;
    int dpat;     // 0 = dval always, 1 = dval every other cycle, 2 = random
    int simf;     // last lval and fval fall together
    int exp_vld;  // -1 = take from the model
    int exp_lines;
    int exp_ll;
    int exp_ov;
  } vec_t;

  vec_t vecs[7];

  int n_pass = 0;
  int n_total = 0;
  int n_frst = 0;
  int n_fdone = 0;
  logic [47:0] got_q[$];
  logic [47:0] exp_q[$];
  logic        amode;
  logic        m_ll;
  logic        expect_end;

  always @(negedge sys_clk) begin
    if (pk.data_vld === 1'b1) got_q.push_back(pk.data_out);
    if (pk.frame_rst === 1'b1) n_frst <= n_frst + 1;
    if (frame_done === 1'b1) n_fdone <= n_fdone + 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic put(input logic f, input logic l, input logic d, input logic a,
                     input logic [47:0] dat);
    cl_fval = f;
    cl_lval = l;
    cl_dval = d;
    arm     = a;
    cl_data = dat;
    step();
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  // Drives one frame; when rec is set, the expected beat stream is built from the
  // line/beat limits: only the first max_lines lines and first max_beats dval beats
  // of each line survive.
  task automatic drive_frame(input int nl, input int nb, input int dpat, input int simf,
                             input int rec, input int arm_at);
    int ci;
    int cnt;
    logic d;
    logic [47:0] cur;
    ci = 0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 1'b0, 1'b0, ci == arm_at, rnd48());
      ci++;
    end
    for (int l = 0; l < nl; l++) begin
      cnt = 0;
      for (int b = 0; b < nb; b++) begin
        if (dpat == 0) d = 1'b1;
        else if (dpat == 1) d = (b % 2 == 0);
        else d = ($urandom_range(0, 1) == 1);
        cur = rnd48();
        if (rec != 0 && d) begin
          if (max_lines == 0 || l < int'(max_lines)) begin
            if (max_beats == 0 || cnt < int'(max_beats))
              exp_q.push_back(amode ? cur : {24'h0, cur[23:0]});
            else
              m_ll = 1'b1;
          end
          cnt++;
        end
        put(1'b1, 1'b1, d, ci == arm_at, cur);
        ci++;
      end
      if (!(simf != 0 && l == nl - 1)) begin
        for (int g = 0; g < 2; g++) begin
          put(1'b1, 1'b0, 1'b0, ci == arm_at, rnd48());
          ci++;
        end
      end
    end
    for (int g = 0; g < 6; g++) put(1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
  endtask

  task automatic check_data(input string tag, input int base);
    int n_bad;
    n_bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= got_q.size()) n_bad++;
      else if (got_q[base + i] !== exp_q[i]) n_bad++;
    end
    chk({tag, "_data"}, n_bad, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int b_rst, b_done, b_vld;
    int e_vld, e_lines, e_ll, e_ov, m_lines, m_ov;
    max_lines = v.ml[15:0];
    max_beats = v.mb[15:0];
    mode_48   = v.mode[0];
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    amode   = v.mode[0];
    mode_48 = ~v.mode[0];
    chk({tag, "_busy_armed"}, busy, 1);
    chk({tag, "_end_hold"}, pk.data_end, expect_end);
    step();
    step();
    b_rst  = n_frst;
    b_done = n_fdone;
    b_vld  = got_q.size();
    exp_q.delete();
    m_ll = 1'b0;
    drive_frame(v.nl, v.nb, v.dpat, v.simf, 1, -1);

    m_lines = (v.ml == 0 || v.nl < v.ml) ? v.nl : v.ml;
    m_ov    = (v.ml != 0 && (v.nl > v.ml || (v.nl == v.ml && v.simf == 0))) ? 1 : 0;
    e_vld   = (v.exp_vld >= 0) ? v.exp_vld : exp_q.size();
    e_lines = (v.exp_vld >= 0) ? v.exp_lines : m_lines;
    e_ll    = (v.exp_vld >= 0) ? v.exp_ll : int'(m_ll);
    e_ov    = (v.exp_vld >= 0) ? v.exp_ov : m_ov;

    chk({tag, "_frame_rst"}, n_frst - b_rst, 1);
    chk({tag, "_frame_done"}, n_fdone - b_done, 1);
    chk({tag, "_vld_count"}, got_q.size() - b_vld, e_vld);
    check_data(tag, b_vld);
    chk({tag, "_line_cnt"}, line_cnt, e_lines);
    chk({tag, "_err_ll"}, err_long_line, e_ll);
    chk({tag, "_err_ov"}, err_overrun, e_ov);
    chk({tag, "_data_sel"}, pk.data_sel, v.mode);
    chk({tag, "_data_end"}, pk.data_end, 1);
    chk({tag, "_busy_done"}, busy, 0);
    expect_end = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int b_rst, b_vld, upper_seen;
    vec_t rv;

    //          mode nl nb ml mb dp sf vld lines ll ov
    vecs[0] = '{0, 4, 8, 0, 0, 0, 0, 32, 4, 0, 0};
    vecs[1] = '{0, 3, 8, 0, 5, 0, 0, 15, 3, 1, 0};
    vecs[2] = '{1, 4, 8, 2, 0, 0, 0, 16, 2, 0, 1};
    vecs[3] = '{0, 3, 8, 0, 0, 1, 1, 12, 3, 0, 0};
    vecs[4] = '{1, 2, 6, 2, 0, 0, 1, 12, 2, 0, 0};
    vecs[5] = '{1, 2, 6, 2, 4, 0, 0,  8, 2, 1, 1};
    vecs[6] = '{0, 2, 8, 0, 8, 0, 0, 16, 2, 0, 0};

    reset = 1'b1;
    cl_fval = 1'b0; cl_lval = 1'b0; cl_dval = 1'b0; cl_data = '0;
    mode_48 = 1'b0; arm = 1'b0; abort = 1'b0;
    max_lines = '0; max_beats = '0;
    expect_end = 1'b0;
    amode = 1'b0;
    m_ll = 1'b0;
    repeat (3) step();
    chk("rst_data_vld", pk.data_vld, 0);
    chk("rst_data_out", pk.data_out, 0);
    chk("rst_data_end", pk.data_end, 0);
    chk("rst_frame_rst", pk.frame_rst, 0);
    chk("rst_data_sel", pk.data_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_errs", {err_long_line, err_overrun}, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Arm while a frame is in flight: that frame is skipped, the next one captured.
    max_lines = '0;
    max_beats = '0;
    mode_48 = 1'b1;
    amode = 1'b1;
    b_rst = n_frst;
    drive_frame(3, 4, 0, 0, 0, 5);
    chk("midarm_busy", busy, 1);
    chk("midarm_no_rst", n_frst - b_rst, 0);
    mode_48 = 1'b0;
    exp_q.delete();
    b_vld = got_q.size();
    drive_frame(2, 5, 0, 0, 1, -1);
    chk("midarm_frame_rst", n_frst - b_rst, 1);
    chk("midarm_vld_count", got_q.size() - b_vld, 10);
    check_data("midarm", b_vld);
    chk("midarm_data_sel", pk.data_sel, 1);
    upper_seen = 0;
    for (int i = b_vld; i < got_q.size(); i++)
      if (got_q[i][47:24] != 24'h0) upper_seen = 1;
    chk("midarm_upper", upper_seen, 1);
    expect_end = 1'b1;

    // Abort in ACTIVE mid-line.
    mode_48 = 1'b0;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) put(1'b1, 1'b0, 1'b0, 1'b0, rnd48());
    for (int i = 0; i < 4; i++) put(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    chk("abort_pre_vld", pk.data_vld, 1);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    put(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    abort = 1'b0;
    chk("abort_vld", pk.data_vld, 0);
    chk("abort_end", pk.data_end, 0);
    chk("abort_busy", busy, 0);
    put(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    put(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    chk("abort_idle_vld", pk.data_vld, 0);
    for (int g = 0; g < 6; g++) put(1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    expect_end = 1'b0;
    run_vec(vecs[0], "post_abort");

    // Asynchronous reset mid-line.
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) put(1'b1, 1'b0, 1'b0, 1'b0, rnd48());
    for (int i = 0; i < 4; i++) put(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    #3;
    reset = 1'b1;
    #1;
    chk("arst_vld", pk.data_vld, 0);
    chk("arst_data_out", pk.data_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_line_cnt", line_cnt, 0);
    chk("arst_end", pk.data_end, 0);
    put(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    put(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    reset = 1'b0;
    put(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    for (int g = 0; g < 6; g++) put(1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    expect_end = 1'b0;
    run_vec(vecs[1], "post_reset");

    // Randomized frames checked against the line/beat-limit model.
    for (int i = 0; i < 20; i++) begin
      rv.mode = $urandom_range(0, 1);
      rv.nl   = $urandom_range(1, 5);
      rv.nb   = $urandom_range(1, 10);
      rv.ml   = $urandom_range(0, 4);
      rv.mb   = $urandom_range(0, 8);
      rv.dpat = 2;
      rv.simf = $urandom_range(0, 1);
      rv.exp_vld = -1;
      rv.exp_lines = 0;
      rv.exp_ll = 0;
      rv.exp_ov = 0;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
